// File: rtl/mem_access_ctrl.sv
// Byte/half/word load-store front end for a 1-cycle-latency word memory; sub-word stores use read-modify-write.
// Latency fault 1, word store 2, load 3, sub-word store 4 cycles; stall_o holds the pipeline until the DONE cycle.
module mem_access_ctrl #(
    parameter int IDX_W = 8
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        req_valid_i,
    input  logic        req_write_i,
    input  logic [1:0]  req_size_i,
    input  logic        req_unsigned_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    input  logic [31:0] mem_rdata_i,
    output logic        mem_read_o,
    output logic        mem_write_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic        stall_o,
    output logic        resp_valid_o,
    output logic [31:0] rdata_o,
    output logic        misalign_o
);

    typedef enum logic [2:0] {IDLE, RD, CAP, MRG, WR, DONE} state_t;

    state_t             state, nextState;
    logic               reqWrite, reqUnsigned, err, misalignReq;
    logic [1:0]         reqSize, byteOff;
    logic [IDX_W-1:0]   wordIdx;
    logic [31:0]        wdataLat, mergeReg, loadData, mergeData;
    logic [7:0]         laneByte;
    logic [15:0]        laneHalf;
    logic               unusedAddrBits;

    // Address bits above the word index alias; they are intentionally dropped.
    assign unusedAddrBits = &{1'b0, req_addr_i[31:IDX_W+2]};

    always_comb begin
        misalignReq = (req_size_i == 2'b11)
                   || (req_size_i == 2'b01 && req_addr_i[0])
                   || (req_size_i == 2'b10 && req_addr_i[1:0] != 2'b00);
    end

    always_comb begin
        laneByte = mem_rdata_i[{byteOff, 3'b000} +: 8];
        laneHalf = mem_rdata_i[{byteOff[1], 4'b0000} +: 16];
        loadData = mem_rdata_i;
        case (reqSize)
            2'b00:   loadData = {{24{~reqUnsigned & laneByte[7]}}, laneByte};
            2'b01:   loadData = {{16{~reqUnsigned & laneHalf[15]}}, laneHalf};
            default: loadData = mem_rdata_i;
        endcase
    end

    always_comb begin
        mergeData = mem_rdata_i;
        case (reqSize)
            2'b00:   mergeData[{byteOff, 3'b000} +: 8] = wdataLat[7:0];
            2'b01:   mergeData[{byteOff[1], 4'b0000} +: 16] = wdataLat[15:0];
            default: mergeData = wdataLat;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state       <= IDLE;
            reqWrite    <= 1'b0;
            reqUnsigned <= 1'b0;
            reqSize     <= 2'b00;
            byteOff     <= 2'b00;
            wordIdx     <= '0;
            wdataLat    <= '0;
            err         <= 1'b0;
            mergeReg    <= '0;
            rdata_o     <= '0;
        end else begin
            state <= nextState;
            if (state == IDLE && req_valid_i) begin
                reqWrite    <= req_write_i;
                reqUnsigned <= req_unsigned_i;
                reqSize     <= req_size_i;
                byteOff     <= req_addr_i[1:0];
                wordIdx     <= req_addr_i[IDX_W+1:2];
                wdataLat    <= req_wdata_i;
                err         <= misalignReq;
            end
            if (state == CAP) rdata_o  <= loadData;
            if (state == MRG) mergeReg <= mergeData;
        end
    end

    always_comb begin
        nextState    = state;
        mem_read_o   = 1'b0;
        mem_write_o  = 1'b0;
        mem_addr_o   = '0;
        mem_wdata_o  = '0;
        stall_o      = 1'b0;
        resp_valid_o = 1'b0;
        misalign_o   = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid_i) begin
                    stall_o = 1'b1;
                    if (misalignReq)                              nextState = DONE;
                    else if (req_write_i && req_size_i == 2'b10) nextState = WR;
                    else                                          nextState = RD;
                end
            end
            RD: begin
                mem_read_o = 1'b1;
                mem_addr_o = {{(32-IDX_W){1'b0}}, wordIdx};
                stall_o    = 1'b1;
                nextState  = reqWrite ? MRG : CAP;
            end
            CAP: begin
                stall_o   = 1'b1;
                nextState = DONE;
            end
            MRG: begin
                stall_o   = 1'b1;
                nextState = WR;
            end
            WR: begin
                mem_write_o = 1'b1;
                mem_addr_o  = {{(32-IDX_W){1'b0}}, wordIdx};
                mem_wdata_o = (reqSize == 2'b10) ? wdataLat : mergeReg;
                stall_o     = 1'b1;
                nextState   = DONE;
            end
            DONE: begin
                resp_valid_o = 1'b1;
                misalign_o   = err;
                nextState    = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: word memory model, per-cycle reference model compare, directed load/store vectors.
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid_i, req_write_i, req_unsigned_i;
    logic [1:0]  req_size_i;
    logic [31:0] req_addr_i, req_wdata_i, memRdata;
    logic        mem_read_o, mem_write_o, stall_o, resp_valid_o, misalign_o;
    logic [31:0] mem_addr_o, mem_wdata_o, rdata_o;

    always #5 clk = ~clk;

    mem_access_ctrl #(.IDX_W(8)) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .req_valid_i(req_valid_i), .req_write_i(req_write_i), .req_size_i(req_size_i),
        .req_unsigned_i(req_unsigned_i), .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
        .mem_rdata_i(memRdata), .mem_read_o(mem_read_o), .mem_write_o(mem_write_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .stall_o(stall_o),
        .resp_valid_o(resp_valid_o), .rdata_o(rdata_o), .misalign_o(misalign_o)
    );

    // Data memory: 256 x 32, registered read, synchronous write.
    logic [31:0] mem [256];
    always @(posedge clk) begin
        if (mem_read_o)  memRdata <= mem[mem_addr_o[7:0]];
        if (mem_write_o) mem[mem_addr_o[7:0]] <= mem_wdata_o;
    end

    int vectors = 0;
    int fails   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: architectural memory plus cycles-to-response for the accepted request.
    logic [31:0] modelMem [256];
    int          remaining = 0;
    bit          inDone = 0;
    bit          pendErr, pendLoad, pendStore;
    int          pendRd, pendWr;
    logic [7:0]  pendIdx;
    logic [31:0] pendRdata, pendMerged;
    logic [31:0] expRdata = 32'h0;

    function automatic logic [31:0] extract(input logic [31:0] word, input logic [1:0] size,
                                            input bit uns, input logic [1:0] off);
        logic [31:0] b, h;
        b = (word >> (8 * off)) & 32'hFF;
        h = (word >> (16 * off[1])) & 32'hFFFF;
        case (size)
            2'd0:    return (uns || !b[7])  ? b : (b | 32'hFFFF_FF00);
            2'd1:    return (uns || !h[15]) ? h : (h | 32'hFFFF_0000);
            default: return word;
        endcase
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] word, input logic [31:0] wdata,
                                          input logic [1:0] size, input logic [1:0] off);
        logic [31:0] mask;
        int          sh;
        if (size == 2'd0)      begin sh = 8 * off;     mask = 32'hFF   << sh; end
        else if (size == 2'd1) begin sh = 16 * off[1]; mask = 32'hFFFF << sh; end
        else                   begin sh = 0;           mask = 32'hFFFF_FFFF;  end
        return (word & ~mask) | ((wdata << sh) & mask);
    endfunction

    task automatic modelComplete();
        if (pendLoad && !pendErr) expRdata = pendRdata;
        if (pendStore) modelMem[pendIdx] = pendMerged;
    endtask

    task automatic modelAccept();
        int lat;
        pendIdx    = req_addr_i[9:2];
        pendErr    = (req_size_i == 2'd3) || (req_size_i == 2'd1 && req_addr_i[0])
                  || (req_size_i == 2'd2 && req_addr_i[1:0] != 2'd0);
        pendLoad   = !req_write_i;
        pendStore  = req_write_i && !pendErr;
        pendRd     = (!pendErr && (!req_write_i || req_size_i != 2'd2)) ? 1 : 0;
        pendWr     = pendStore ? 1 : 0;
        pendRdata  = extract(modelMem[pendIdx], req_size_i, req_unsigned_i, req_addr_i[1:0]);
        pendMerged = merge(modelMem[pendIdx], req_wdata_i, req_size_i, req_addr_i[1:0]);
        lat = pendErr ? 1 : (!req_write_i ? 3 : (req_size_i == 2'd2 ? 2 : 4));
        remaining = lat - 1;
        inDone    = (lat == 1);
        if (inDone) modelComplete();
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            remaining = 0;
            inDone    = 0;
            expRdata  = 32'h0;
        end else if (remaining > 0) begin
            remaining--;
            if (remaining == 0) begin
                inDone = 1;
                modelComplete();
            end
        end else if (inDone) begin
            inDone = 0;
        end else if (req_valid_i) begin
            modelAccept();
        end
    end

    int rdSeen = 0;
    int wrSeen = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("reset_resp", 32'(resp_valid_o), 32'h0);
            chk("reset_misalign", 32'(misalign_o), 32'h0);
            chk("reset_rdata", rdata_o, 32'h0);
            chk("reset_memrw", 32'({mem_read_o, mem_write_o}), 32'h0);
            rdSeen = 0;
            wrSeen = 0;
        end else begin
            if (mem_read_o)  rdSeen++;
            if (mem_write_o) wrSeen++;
            chk("rd_wr_exclusive", 32'(mem_read_o & mem_write_o), 32'h0);
            if (mem_read_o || mem_write_o) chk("mem_addr", mem_addr_o, {24'h0, pendIdx});
            if (mem_write_o) chk("mem_wdata", mem_wdata_o, pendMerged);
            chk("stall", 32'(stall_o), 32'(remaining > 0 || (!inDone && req_valid_i)));
            chk("resp_valid", 32'(resp_valid_o), 32'(inDone));
            chk("misalign", 32'(misalign_o), 32'(inDone && pendErr));
            chk("rdata", rdata_o, expRdata);
            if (inDone) begin
                chk("read_pulses", 32'(rdSeen), 32'(pendRd));
                chk("write_pulses", 32'(wrSeen), 32'(pendWr));
                rdSeen = 0;
                wrSeen = 0;
            end
        end
    end

    // Called in IDLE just after an edge; the next edge accepts the request.
    task automatic doReq(input bit w, input logic [1:0] size, input bit uns, input logic [31:0] addr,
                         input logic [31:0] wdata, input int expLat, input bit chkData,
                         input logic [31:0] expData, input bit hold);
        int got;
        req_write_i    = w;
        req_size_i     = size;
        req_unsigned_i = uns;
        req_addr_i     = addr;
        req_wdata_i    = wdata;
        req_valid_i    = 1'b1;
        @(posedge clk); #1;
        if (!hold) req_valid_i = 1'b0;
        got = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (resp_valid_o) begin
                got = k;
                break;
            end
        end
        chk("latency", 32'(got), 32'(expLat));
        if (chkData) chk("load_result", rdata_o, expData);
        @(posedge clk); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        req_valid_i = 1'b0; req_write_i = 1'b0; req_unsigned_i = 1'b0;
        req_size_i = 2'd0; req_addr_i = 32'h0; req_wdata_i = 32'h0;
        for (int i = 0; i < 256; i++) begin
            mem[i]      = 32'h0;
            modelMem[i] = 32'h0;
        end
        mem[0] = 32'h80FF_7F01; modelMem[0] = 32'h80FF_7F01;
        mem[2] = 32'h1122_3344; modelMem[2] = 32'h1122_3344;
        mem[8] = 32'h5566_7788; modelMem[8] = 32'h5566_7788;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // Word store / load and address aliasing.
        doReq(1, 2'd2, 0, 32'h40,  32'hDEAD_BEEF, 2, 0, 32'h0, 0);
        chk("mem_sw_0x40", mem[16], 32'hDEAD_BEEF);
        doReq(0, 2'd2, 0, 32'h40,  32'h0, 3, 1, 32'hDEAD_BEEF, 0);
        doReq(0, 2'd2, 0, 32'h440, 32'h0, 3, 1, 32'hDEAD_BEEF, 0);

        // Sub-word load extraction and extension.
        doReq(0, 2'd0, 0, 32'h3, 32'h0, 3, 1, 32'hFFFF_FF80, 0);
        doReq(0, 2'd0, 1, 32'h3, 32'h0, 3, 1, 32'h0000_0080, 0);
        doReq(0, 2'd1, 0, 32'h2, 32'h0, 3, 1, 32'hFFFF_80FF, 0);
        doReq(0, 2'd1, 1, 32'h0, 32'h0, 3, 1, 32'h0000_7F01, 0);

        // Read-modify-write; upper wdata bits must not leak into memory.
        doReq(1, 2'd0, 0, 32'h9, 32'hFFFF_FFAA, 4, 0, 32'h0, 0);
        chk("mem_sb_0x9", mem[2], 32'h1122_AA44);
        doReq(1, 2'd1, 0, 32'hA, 32'h5555_BEEF, 4, 0, 32'h0, 0);
        chk("mem_sh_0xA", mem[2], 32'hBEEF_AA44);
        doReq(0, 2'd2, 0, 32'h8, 32'h0, 3, 1, 32'hBEEF_AA44, 0);

        // Faults: no memory traffic, rdata_o keeps the previous load result.
        doReq(0, 2'd1, 0, 32'h5, 32'h0,         1, 1, 32'hBEEF_AA44, 0);
        doReq(1, 2'd2, 0, 32'h6, 32'hFFFF_FFFF, 1, 1, 32'hBEEF_AA44, 0);
        doReq(0, 2'd3, 0, 32'h0, 32'h0,         1, 1, 32'hBEEF_AA44, 0);
        chk("mem_after_fault", mem[1], 32'h0);

        // Back-to-back with req_valid_i held high.
        doReq(0, 2'd2, 0, 32'h0,  32'h0,         3, 1, 32'h80FF_7F01, 1);
        doReq(1, 2'd2, 0, 32'h44, 32'hCAFE_F00D, 2, 0, 32'h0,         1);
        doReq(0, 2'd2, 0, 32'h44, 32'h0,         3, 1, 32'hCAFE_F00D, 0);

        // Reset during the merge cycle of a byte store.
        req_write_i = 1'b1; req_size_i = 2'd0; req_unsigned_i = 1'b0;
        req_addr_i = 32'h21; req_wdata_i = 32'h0000_0099; req_valid_i = 1'b1;
        @(posedge clk); #1 req_valid_i = 1'b0;
        @(posedge clk); #2 rst_n = 1'b0;
        #1;
        chk("rst_write_now", 32'(mem_write_o), 32'h0);
        chk("rst_stall_now", 32'(stall_o), 32'h0);
        chk("rst_rdata_now", rdata_o, 32'h0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("mem_after_reset", mem[8], 32'h5566_7788);
        doReq(0, 2'd2, 0, 32'h20, 32'h0, 3, 1, 32'h5566_7788, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
